// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Word-index width for a store of the given depth (at least one bit).
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word store with per-byte write enables, registered read port and async clear.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned IDX_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic              rd_clr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read data holds until the next read or an explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end else if (rd_clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [BE_W-1:0]   req_be_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int unsigned IDX_W  = idx_width(DEPTH_WORDS);
    localparam bit          DIRECT = (LATENCY == 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ready_q;
    logic              valid_q;
    logic              err_q;
    logic              cap_write_q;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [DATA_W-1:0] cap_wdata_q;
    logic [BE_W-1:0]   cap_be_q;

    logic              accept_c;
    logic              fire_c;
    logic              acc_err_c;
    logic              sel_write_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic [BE_W-1:0]   sel_be_c;
    logic [ADDR_W-1:0] word_idx_c;
    logic              wr_en_c;
    logic              rd_en_c;
    logic              rd_clr_c;

    // Access happens on the edge entering RESP; with LATENCY=1 that is the accept edge itself.
    always_comb begin
        accept_c    = (state_q == ST_IDLE) && ready_q && req_valid_i;
        fire_c      = (DIRECT && accept_c) || ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));
        sel_write_c = (state_q == ST_IDLE) ? req_write_i : cap_write_q;
        sel_addr_c  = (state_q == ST_IDLE) ? req_addr_i  : cap_addr_q;
        sel_wdata_c = (state_q == ST_IDLE) ? req_wdata_i : cap_wdata_q;
        sel_be_c    = (state_q == ST_IDLE) ? req_be_i    : cap_be_q;
        word_idx_c  = {2'b00, sel_addr_c[ADDR_W-1:2]};
        acc_err_c   = (sel_addr_c[1:0] != 2'b00) || (word_idx_c >= ADDR_W'(DEPTH_WORDS));
        wr_en_c     = fire_c && !acc_err_c && sel_write_c;
        rd_en_c     = fire_c && !acc_err_c && !sel_write_c;
        rd_clr_c    = (fire_c && (acc_err_c || sel_write_c))
                   || ((state_q == ST_RESP) && rsp_ready_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            cap_write_q <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_be_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept_c) begin
                        ready_q     <= 1'b0;
                        cap_write_q <= req_write_i;
                        cap_addr_q  <= req_addr_i;
                        cap_wdata_q <= req_wdata_i;
                        cap_be_q    <= req_be_i;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        if (DIRECT) begin
                            state_q <= ST_RESP;
                            valid_q <= 1'b1;
                            err_q   <= acc_err_c;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (fire_c) begin
                        state_q <= ST_RESP;
                        valid_q <= 1'b1;
                        err_q   <= acc_err_c;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (wr_en_c),
        .rd_en_i  (rd_en_c),
        .rd_clr_i (rd_clr_c),
        .idx_i    (IDX_W'(word_idx_c)),
        .wdata_i  (sel_wdata_c),
        .be_i     (sel_be_c),
        .rdata_o  (rsp_rdata_o)
    );

    assign req_ready_o = ready_q;
    assign rsp_valid_o = valid_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one responder at LATENCY=2 and one at LATENCY=1.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_be;

    logic        b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_be;

    int n_checks = 0;
    int n_fails  = 0;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (a_req_valid),
        .req_ready_o (a_req_ready),
        .req_write_i (a_req_write),
        .req_addr_i  (a_req_addr),
        .req_wdata_i (a_req_wdata),
        .req_be_i    (a_req_be),
        .rsp_valid_o (a_rsp_valid),
        .rsp_ready_i (a_rsp_ready),
        .rsp_rdata_o (a_rsp_rdata),
        .rsp_err_o   (a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (b_req_valid),
        .req_ready_o (b_req_ready),
        .req_write_i (b_req_write),
        .req_addr_i  (b_req_addr),
        .req_wdata_i (b_req_wdata),
        .req_be_i    (b_req_be),
        .rsp_valid_o (b_rsp_valid),
        .rsp_ready_i (b_rsp_ready),
        .rsp_rdata_o (b_rsp_rdata),
        .rsp_err_o   (b_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request on the LATENCY=2 instance with rsp_ready held high; lat counts cycles to valid.
    task automatic a_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat);
        int budget;
        a_req_write = wr;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_req_be    = be;
        a_req_valid = 1'b1;
        budget = 0;
        while (!a_req_ready && budget < 20) begin
            step();
            budget++;
        end
        step();
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        rdata = a_rsp_rdata;
        err   = a_rsp_err;
        step();
    endtask

    task automatic a_check_xfer(input string tag, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rdata;
        logic        err;
        int          lat;
        a_xfer(wr, addr, wdata, be, rdata, err, lat);
        check({tag, ".lat"}, 32'(lat), 32'd2);
        check({tag, ".rdata"}, rdata, exp_rdata);
        check({tag, ".err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        rst_n       = 1'b0;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
        a_rsp_ready = 1'b1;
        b_rsp_ready = 1'b1;

        // Reset state
        #2;
        check("rst.a_ready", 32'(a_req_ready), 32'd0);
        check("rst.a_valid", 32'(a_rsp_valid), 32'd0);
        check("rst.a_rdata", a_rsp_rdata, 32'd0);
        check("rst.a_err", 32'(a_rsp_err), 32'd0);
        step();
        step();
        check("rst.b_ready", 32'(b_req_ready), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst.a_ready", 32'(a_req_ready), 32'd1);
        check("post_rst.b_ready", 32'(b_req_ready), 32'd1);

        // LATENCY=1 back-to-back: store 0x8 then loads of 0x8 with valid held high
        b_req_write = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'hCAFEF00D; b_req_be = 4'hF;
        b_req_valid = 1'b1;
        step();
        check("b2b.c1.valid", 32'(b_rsp_valid), 32'd1);
        check("b2b.c1.ready", 32'(b_req_ready), 32'd0);
        check("b2b.c1.err", 32'(b_rsp_err), 32'd0);
        check("b2b.c1.rdata", b_rsp_rdata, 32'd0);
        b_req_write = 1'b0;
        step();
        check("b2b.c2.valid", 32'(b_rsp_valid), 32'd0);
        check("b2b.c2.ready", 32'(b_req_ready), 32'd1);
        step();
        check("b2b.c3.valid", 32'(b_rsp_valid), 32'd1);
        check("b2b.c3.rdata", b_rsp_rdata, 32'hCAFEF00D);
        check("b2b.c3.ready", 32'(b_req_ready), 32'd0);
        step();
        check("b2b.c4.valid", 32'(b_rsp_valid), 32'd0);
        check("b2b.c4.rdata", b_rsp_rdata, 32'd0);
        step();
        check("b2b.c5.valid", 32'(b_rsp_valid), 32'd1);
        check("b2b.c5.rdata", b_rsp_rdata, 32'hCAFEF00D);
        b_req_valid = 1'b0;
        step();
        check("b2b.c6.valid", 32'(b_rsp_valid), 32'd0);

        // LATENCY=2 store/load, partial store, errors, be=0
        a_check_xfer("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
        check("st_full.idle_valid", 32'(a_rsp_valid), 32'd0);
        check("st_full.idle_ready", 32'(a_req_ready), 32'd1);
        a_check_xfer("ld_full", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0);
        a_check_xfer("st_part", 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'd0, 1'b0);
        a_check_xfer("ld_part", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDE22BE44, 1'b0);
        a_check_xfer("ld_misal", 1'b0, 32'h13, 32'd0, 4'h0, 32'd0, 1'b1);
        a_check_xfer("ld_oob", 1'b0, 32'h400, 32'd0, 4'h0, 32'd0, 1'b1);
        a_check_xfer("st_misal", 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1);
        a_check_xfer("st_be0", 1'b1, 32'h10, 32'h00000000, 4'h0, 32'd0, 1'b0);
        a_check_xfer("ld_after_err", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDE22BE44, 1'b0);
        a_check_xfer("ld_last", 1'b0, 32'h3FC, 32'd0, 4'h0, 32'd0, 1'b0);

        // Stall: rsp_ready low for 5 cycles, a store kept on the request bus meanwhile
        a_rsp_ready = 1'b0;
        a_req_write = 1'b0; a_req_addr = 32'h10; a_req_be = 4'h0; a_req_valid = 1'b1;
        step();
        a_req_write = 1'b1; a_req_wdata = 32'h0; a_req_be = 4'hF;
        step();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall.c%0d.valid", k), 32'(a_rsp_valid), 32'd1);
            check($sformatf("stall.c%0d.rdata", k), a_rsp_rdata, 32'hDE22BE44);
            check($sformatf("stall.c%0d.ready", k), 32'(a_req_ready), 32'd0);
            step();
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        step();
        check("stall.release_valid", 32'(a_rsp_valid), 32'd0);
        check("stall.release_ready", 32'(a_req_ready), 32'd1);
        a_check_xfer("stall.ld_after", 1'b0, 32'h10, 32'd0, 4'h0, 32'hDE22BE44, 1'b0);

        // Reset pulsed while a store to 0x20 waits
        a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h55AA55AA; a_req_be = 4'hF;
        a_req_valid = 1'b1;
        step();
        a_req_valid = 1'b0;
        check("rst_wait.in_wait_valid", 32'(a_rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_wait.valid", 32'(a_rsp_valid), 32'd0);
        check("rst_wait.ready", 32'(a_req_ready), 32'd0);
        check("rst_wait.rdata", a_rsp_rdata, 32'd0);
        step();
        check("rst_wait.held_valid", 32'(a_rsp_valid), 32'd0);
        rst_n = 1'b1;
        step();
        check("rst_wait.ready_after", 32'(a_req_ready), 32'd1);
        a_check_xfer("rst_wait.ld20", 1'b0, 32'h20, 32'd0, 4'h0, 32'd0, 1'b0);
        a_check_xfer("rst_wait.ld10", 1'b0, 32'h10, 32'd0, 4'h0, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request accept to response valid; legal range 1..15.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  responder can accept a request.
REQ-007 SHALL have port req_write_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr_i  input  32  byte address.
REQ-009 SHALL have port req_wdata_i  input  32  store data.
REQ-010 SHALL have port req_be_i  input  4  store byte enables; bit i selects wdata[8i+7:8i].
REQ-011 SHALL have port rsp_valid_o  output  1  response present.
REQ-012 SHALL have port rsp_ready_i  input  1  requester takes the response.
REQ-013 SHALL have port rsp_rdata_o  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err_o  output  1  access error.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 SHALL assert req_ready_o only in IDLE, so at most one request is outstanding.
REQ-017 SHALL accept a request when req_valid_i & req_ready_o on a clock edge, capturing write, addr, wdata and be, and leaving IDLE.
REQ-018 SHALL, on accept, load the latency counter with LATENCY-1; for LATENCY=1 the FSM goes directly to RESP, otherwise to WAIT.
REQ-019 SHALL, in WAIT, decrement the counter each cycle; on the edge where it is 0, perform the access and enter RESP.
REQ-020 SHALL make rsp_valid_o rise exactly LATENCY cycles after the accept edge.
REQ-021 SHALL, in RESP, hold rsp_valid_o, rsp_rdata_o and rsp_err_o stable until rsp_ready_i is high; on that edge return to IDLE.
REQ-022 SHALL allow the next request to be accepted no earlier than the cycle after the response handshake.
REQ-023 SHALL use word index addr[31:2].
REQ-024 SHALL flag an error when addr[1:0] != 0 or the word index >= DEPTH_WORDS.
REQ-025 SHALL, on error, not modify storage, return rdata 0 and err 1; the response still follows the REQ-020 timing.
REQ-026 SHALL, on a store, update only the bytes whose be bit is 1; be=4'b0000 is a legal no-op with err 0.
REQ-027 SHALL, on a load, return the full word as it stands after all previously responded stores.
REQ-028 SHALL ignore req_* inputs outside IDLE and keep no side effects from them.
REQ-029 SHALL drive rsp_valid_o to 0 in IDLE and WAIT and drive rsp_rdata_o/rsp_err_o to 0 when rsp_valid_o is 0.

Reset
REQ-030 SHALL, when rst_n is low, force state IDLE, counter 0, req_ready_o 0 during reset, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0 and all storage words 0.
REQ-031 SHALL set req_ready_o to 1 in the first cycle after rst_n deasserts.
REQ-032 SHALL discard a pending uncommitted store when reset is asserted mid-WAIT; it never reaches storage.

Structure
REQ-033 SHALL place the FSM state enum, the counter width (4 bits) and the byte-enable width constant in the shared package dmem_pkg.
REQ-034 SHALL contain one sub-module, dmem_array: a byte-enable write, registered-read word store with async clear.
REQ-035 SHALL keep the FSM, counter and error check in dmem_responder.

Verification
REQ-036 SHALL cover: LATENCY=2, store addr 0x10, wdata 0xDEADBEEF, be 4'hF, rsp_ready_i=1 -> rsp_valid_o 2 cycles after accept, err 0; then load 0x10 -> rdata 0xDEADBEEF.
REQ-037 SHALL cover: store 0x10 with wdata 0x11223344, be 4'b0101 over existing 0xDEADBEEF -> later load returns 0xDE22BE44.
REQ-038 SHALL cover: load 0x13 (misaligned) and load 0x400 with DEPTH_WORDS=256 -> err 1, rdata 0, storage unchanged.
REQ-039 SHALL cover: rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and rsp_rdata_o stable, req_ready_o 0 throughout, and no new request accepted.
REQ-040 SHALL cover: rst_n pulsed low in WAIT of a store to 0x20 -> outputs 0 immediately, and a post-reset load of 0x20 returns 0.
REQ-041 SHALL cover: LATENCY=1 back-to-back requests with req_valid_i held high -> accepts every other cycle and responses arrive 1 cycle after each accept.
